// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer.
package mips_mc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    FAULT  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic size_t access_size(input logic [5:0] op);
    if (op inside {OP_LB, OP_LBU, OP_SB}) return BYTE;
    if (op inside {OP_LH, OP_LHU, OP_SH}) return HALF;
    return WORD;
  endfunction

endpackage

// File: rtl/mips_mc_sequencer_lanes.sv
// Byte-lane decoder: access size + low address bits -> lane mask and misalign flag.
module mips_lane_decoder
  import mips_mc_pkg::*;
#(
  parameter int LANES = 4,
  localparam int AW = $clog2(LANES)
) (
  input  logic [1:0]       size,
  input  logic [AW-1:0]    addr_lo,
  output logic [LANES-1:0] lane_mask,
  output logic             misalign
);

  always_comb begin
    lane_mask = '0;
    misalign  = 1'b0;
    case (size)
      BYTE: lane_mask[addr_lo] = 1'b1;
      HALF: begin
        lane_mask[{addr_lo[AW-1:1], 1'b0}] = 1'b1;
        lane_mask[{addr_lo[AW-1:1], 1'b1}] = 1'b1;
        misalign = addr_lo[0];
      end
      default: begin
        lane_mask = '1;
        misalign  = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT/FAULT).
// Define MIPS_MEM_TIMEOUT_EN to fault on memory handshakes that stall past TIMEOUT cycles.
module mips_mc_sequencer
  import mips_mc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LANES   = XLEN / 8,
  parameter int TIMEOUT = 15,
  localparam int AW = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic [AW-1:0]    addr_lo,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write_en,
  output logic [LANES-1:0] mem_lane_en,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write_enable,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state
);

  state_t           state_q;
  logic [5:0]       op_q, fn_q;
  logic             zero_q;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    dec_addr;
  logic [LANES-1:0] lane_mask;
  logic             misalign;
  logic             latched_unused;

  // Branch and misalign decisions are made in EXEC on the live inputs;
  // the registered copies serve the MEM stage and later debug visibility.
  assign latched_unused = ^{fn_q, zero_q};

  assign dec_addr = (state_q == EXEC) ? addr_lo : addr_q;

  mips_lane_decoder #(.LANES(LANES)) u_lanes (
    .size      (access_size(op_q)),
    .addr_lo   (dec_addr),
    .lane_mask (lane_mask),
    .misalign  (misalign)
  );

`ifdef MIPS_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
  logic [CW-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      zero_q  <= 1'b0;
      addr_q  <= '0;
`ifdef MIPS_MEM_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state_q)
        FETCH: if (mem_ready) state_q <= DECODE;
        DECODE: begin
          op_q <= opcode;
          fn_q <= func;
          if (opcode == OP_RTYPE && func == FN_SYSCALL) state_q <= HALT;
          else if (opcode == OP_J || opcode == OP_JAL)  state_q <= FETCH;
          else                                          state_q <= EXEC;
        end
        EXEC: begin
          zero_q <= zero;
          addr_q <= addr_lo;
          if (op_q == OP_BEQ || op_q == OP_BNE)         state_q <= FETCH;
          else if (is_load(op_q) || is_store(op_q))     state_q <= misalign ? FAULT : MEM;
          else                                          state_q <= WB;
        end
        MEM:     if (mem_ready) state_q <= is_store(op_q) ? FETCH : WB;
        WB:      state_q <= FETCH;
        HALT:    state_q <= HALT;
        default: state_q <= FAULT;
      endcase
`ifdef MIPS_MEM_TIMEOUT_EN
      // Stall watchdog overrides the case above once the limit is reached.
      if (mem_req && !mem_ready) begin
        if (wait_cnt == TO_MAX) state_q <= FAULT;
        else                    wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
`endif
    end
  end

  always_comb begin
    mem_req          = 1'b0;
    mem_write_en     = 1'b0;
    mem_lane_en      = '0;
    pc_write         = 1'b0;
    ir_write         = 1'b0;
    reg_write_enable = 1'b0;
    halted           = 1'b0;
    fault            = 1'b0;
    case (state_q)
      FETCH: begin
        // Held off while reset is asserted so the first request follows release.
        mem_req     = !rst_b;
        mem_lane_en = mem_req ? '1 : '0;
        ir_write    = mem_req && mem_ready;
        pc_write    = mem_req && mem_ready;
      end
      DECODE: begin
        pc_write         = !(opcode == OP_RTYPE && func == FN_SYSCALL) &&
                           (opcode == OP_J || opcode == OP_JAL);
        reg_write_enable = (opcode == OP_JAL);
      end
      EXEC:
        pc_write = (op_q == OP_BEQ && zero) || (op_q == OP_BNE && !zero);
      MEM: begin
        mem_req      = !rst_b;
        mem_write_en = mem_req && is_store(op_q);
        mem_lane_en  = mem_req ? lane_mask : '0;
      end
      WB:   reg_write_enable = 1'b1;
      HALT: halted = 1'b1;
      default: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Directed bench for mips_mc_sequencer (XLEN=32, 4 lanes, TIMEOUT=15).
module tb_mips_mc_sequencer;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [5:0] opcode, func;
  logic       zero;
  logic [1:0] addr_lo;
  logic       mem_ready;
  logic       mem_req, mem_write_en;
  logic [3:0] mem_lane_en;
  logic       pc_write, ir_write, reg_write_enable, halted, fault;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  mips_mc_sequencer #(.XLEN(32), .LANES(4), .TIMEOUT(15)) dut (
    .clk              (clk),
    .rst_b            (rst_b),
    .opcode           (opcode),
    .func             (func),
    .zero             (zero),
    .addr_lo          (addr_lo),
    .mem_ready        (mem_ready),
    .mem_req          (mem_req),
    .mem_write_en     (mem_write_en),
    .mem_lane_en      (mem_lane_en),
    .pc_write         (pc_write),
    .ir_write         (ir_write),
    .reg_write_enable (reg_write_enable),
    .halted           (halted),
    .fault            (fault),
    .state            (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are changed and outputs sampled 2 ns after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_b = 1'b1;
    #1;
    tick();
    rst_b = 1'b0;
    #1;
  endtask

  initial begin
    rst_b = 1'b1; opcode = 6'h00; func = 6'h00; zero = 1'b0; addr_lo = 2'd0; mem_ready = 1'b0;
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    rst_b = 1'b0;
    #1;
    chk("first_fetch_req", 32'(mem_req), 32'd1);
    chk("first_fetch_lanes", 32'(mem_lane_en), 32'hF);

    // add: FETCH, DECODE, EXEC, WB, FETCH
    opcode = 6'h00; func = 6'h20; mem_ready = 1'b1;
    #1;
    chk("add_fetch_irw", 32'({ir_write, pc_write, mem_write_en}), 32'b110);
    tick(); chk("add_decode", 32'({state, reg_write_enable}), {28'd0, 3'd1, 1'b0});
    tick(); chk("add_exec", 32'({state, reg_write_enable}), {28'd0, 3'd2, 1'b0});
    tick(); chk("add_wb", 32'({state, reg_write_enable}), {28'd0, 3'd4, 1'b1});
    tick(); chk("add_refetch", 32'({state, reg_write_enable}), {28'd0, 3'd0, 1'b0});

    // bne taken/not taken
    opcode = 6'h05; func = 6'h00; zero = 1'b1;
    tick(); tick();
    chk("bne_z1_exec", 32'({state, pc_write}), {28'd0, 3'd2, 1'b0});
    tick(); chk("bne_z1_fetch", 32'(state), 32'd0);
    tick(); zero = 1'b0; tick();
    #1;
    chk("bne_z0_exec", 32'({state, pc_write}), {28'd0, 3'd2, 1'b1});
    tick(); chk("bne_z0_fetch", 32'(state), 32'd0);

    // jal: pc_write and reg_write_enable in DECODE, straight back to FETCH
    opcode = 6'h03;
    tick(); chk("jal_decode", 32'({state, pc_write, reg_write_enable}), {27'd0, 3'd1, 2'b11});
    tick(); chk("jal_fetch", 32'(state), 32'd0);

    // sb to lane 2 with a 3-cycle memory delay
    opcode = 6'h28; addr_lo = 2'd2;
    tick(); tick(); tick();
    mem_ready = 1'b0; addr_lo = 2'd0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_ready = 1'b1; #1; end
      chk("sb_mem_hold", 32'({state, mem_req, mem_write_en, mem_lane_en}),
          {23'd0, 3'd3, 1'b1, 1'b1, 4'b0100});
      if (i < 3) tick();
    end
    tick(); chk("sb_to_fetch", 32'({state, mem_write_en}), {28'd0, 3'd0, 1'b0});

    // lbu at addr 3 -> lane 3 read, then WB
    opcode = 6'h24; addr_lo = 2'd3;
    tick(); tick(); tick();
    chk("lbu_mem", 32'({state, mem_write_en, mem_lane_en}), {24'd0, 3'd3, 1'b0, 4'b1000});
    tick(); chk("lbu_wb", 32'({state, reg_write_enable}), {28'd0, 3'd4, 1'b1});
    tick();

    // lh misaligned -> FAULT, absorbing
    opcode = 6'h21; addr_lo = 2'd1;
    tick(); tick(); tick();
    chk("lh_fault", 32'({state, fault, halted, mem_req}), {26'd0, 3'd6, 3'b110});
    tick(); tick();
    chk("lh_fault_stays", 32'({state, fault, halted, mem_req}), {26'd0, 3'd6, 3'b110});

    // Stall in FETCH with mem_ready low
    do_reset();
    mem_ready = 1'b0;
`ifdef MIPS_MEM_TIMEOUT_EN
    repeat (15) tick();
    chk("to_before", 32'({state, fault}), {28'd0, 3'd0, 1'b0});
    tick();
    chk("to_fault", 32'({state, fault, halted}), {27'd0, 3'd6, 2'b11});
`else
    repeat (20) tick();
    chk("stall_fetch", 32'({state, mem_req, fault}), {27'd0, 3'd0, 2'b10});
`endif

    // syscall -> HALT permanently
    do_reset();
    mem_ready = 1'b1; opcode = 6'h00; func = 6'h0C;
    tick(); tick();
    chk("sys_halt", 32'({state, halted, mem_req, pc_write, reg_write_enable}), {25'd0, 3'd5, 4'b1000});
    repeat (3) tick();
    chk("sys_halt_stays", 32'({state, halted, fault}), {27'd0, 3'd5, 2'b10});

    // async reset in the middle of a stalled sw
    do_reset();
    mem_ready = 1'b1; opcode = 6'h2B; func = 6'h00; addr_lo = 2'd0;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    chk("sw_mem", 32'({state, mem_write_en, mem_lane_en}), {24'd0, 3'd3, 1'b1, 4'hF});
    #1 rst_b = 1'b1;
    #1;
    chk("mid_mem_rst", 32'({state, halted, fault, mem_write_en, mem_req}), {25'd0, 3'd0, 4'b0000});
    rst_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
